// File: rtl/led_target_sel.sv
// Whack-a-LED target selector: picks a random LED on each freq pulse, lights it for a
// bounded window and scores button presses. Optional `TARGET_DEBUG_EN adds dbg_idx.
module led_target_sel #(
  parameter  int NUM_LEDS  = 8,
  parameter  int RND_W     = 13,
  parameter  int ON_CYCLES = 100000000,
  parameter  int NO_REPEAT = 1,
  localparam int IDX_W     = $clog2(NUM_LEDS),
  localparam int TMR_W     = $clog2(ON_CYCLES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                freq,
  input  logic [RND_W-1:0]    rnd,
  input  logic [NUM_LEDS-1:0] btn,
  output logic [NUM_LEDS-1:0] led_onehot,
  output logic                active,
  output logic                hit_pulse,
`ifdef TARGET_DEBUG_EN
  output logic [IDX_W-1:0]    dbg_idx,
`endif
  output logic                miss_pulse
);

  typedef enum logic {IDLE, LIT} state_t;

  localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W+1)'(NUM_LEDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ON_CYCLES - 1);

  state_t              state_q, state_d;
  logic [NUM_LEDS-1:0] led_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [IDX_W-1:0]    prev_q, prev_d;
  logic [NUM_LEDS-1:0] btn_q;
  logic                hit_d, miss_d, load;

  logic [IDX_W:0]      raw_ext, fold_ext;
  logic [IDX_W-1:0]    fold_idx, sel_idx;
  logic [NUM_LEDS-1:0] sel_onehot, press;
  logic                unused_rnd;

  // Only the low IDX_W bits of the LFSR value select the target.
  assign unused_rnd = ^rnd;

  assign raw_ext  = {1'b0, rnd[IDX_W-1:0]};
  assign fold_ext = (raw_ext < NUM_EXT) ? raw_ext : raw_ext - NUM_EXT;
  assign fold_idx = fold_ext[IDX_W-1:0];

  always_comb begin
    sel_idx = fold_idx;
    if (NO_REPEAT == 1 && fold_idx == prev_q)
      sel_idx = (fold_idx == LAST_IDX) ? '0 : fold_idx + IDX_W'(1);
  end

  assign sel_onehot = NUM_LEDS'(1) << sel_idx;
  assign press      = btn & ~btn_q;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    led_d   = led_onehot;
    timer_d = timer_q;
    prev_d  = prev_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: if (freq) load = 1'b1;
      LIT: begin
        if (|(press & led_onehot)) begin
          hit_d = 1'b1;
          if (freq) load = 1'b1;
          else begin
            state_d = IDLE;
            led_d   = '0;
            timer_d = '0;
          end
        end else if (|press) begin
          // A wrong press on the final cycle still expires the target: one miss only.
          miss_d = 1'b1;
          if (timer_q == TMR_LAST) begin
            state_d = IDLE;
            led_d   = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end else if (freq) begin
          miss_d = 1'b1;
          load   = 1'b1;
        end else if (timer_q == TMR_LAST) begin
          miss_d  = 1'b1;
          state_d = IDLE;
          led_d   = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = LIT;
      led_d   = sel_onehot;
      prev_d  = sel_idx;
      timer_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      led_onehot <= '0;
      timer_q    <= '0;
      prev_q     <= '0;
      btn_q      <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      led_onehot <= led_d;
      timer_q    <= timer_d;
      prev_q     <= prev_d;
      btn_q      <= btn;
      hit_pulse  <= hit_d;
      miss_pulse <= miss_d;
    end
  end

  assign active = (state_q == LIT);

`ifdef TARGET_DEBUG_EN
  assign dbg_idx = prev_q;
`endif

endmodule

// File: tb/tb_led_target_sel.sv
// Scoreboard bench for led_target_sel: a cycle-level game model pushes expected outputs,
// a monitor pops and compares them after each clock edge.
module tb_led_target_sel;

  localparam int N   = 8;
  localparam int ON  = 10;
  localparam int N6  = 6;

  typedef struct {
    logic [N-1:0] led;
    logic         active;
    logic         hit;
    logic         miss;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          freq;
  logic [12:0]   rnd;
  logic [N-1:0]  btn;
  logic [N-1:0]  led_onehot;
  logic          active, hit_pulse, miss_pulse;

  logic          freq6;
  logic [12:0]   rnd6;
  logic [N6-1:0] btn6;
  logic [N6-1:0] led6;
  logic          active6, hit6, miss6;

`ifdef TARGET_DEBUG_EN
  logic [2:0] dbg_idx, dbg_idx6;
`endif

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // Reference model: target (-1 when dark), previous index, cycles lit, previous buttons.
  int           m_target;
  int           m_prev;
  int           m_lit;
  logic [N-1:0] m_btn;

  always #5 clk = ~clk;

  led_target_sel #(.NUM_LEDS(N), .RND_W(13), .ON_CYCLES(ON), .NO_REPEAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .freq(freq), .rnd(rnd), .btn(btn),
    .led_onehot(led_onehot), .active(active), .hit_pulse(hit_pulse),
`ifdef TARGET_DEBUG_EN
    .dbg_idx(dbg_idx),
`endif
    .miss_pulse(miss_pulse)
  );

  led_target_sel #(.NUM_LEDS(N6), .RND_W(13), .ON_CYCLES(ON), .NO_REPEAT(1)) dut6 (
    .clk(clk), .rst_n(rst_n), .freq(freq6), .rnd(rnd6), .btn(btn6),
    .led_onehot(led6), .active(active6), .hit_pulse(hit6),
`ifdef TARGET_DEBUG_EN
    .dbg_idx(dbg_idx6),
`endif
    .miss_pulse(miss6)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int pick(input int r, input int n, input int prev);
    int span = 1 << $clog2(n);
    int idx  = r % span;
    if (idx >= n) idx -= n;
    if (idx == prev) idx = (idx + 1) % n;
    return idx;
  endfunction

  task automatic model_reset();
    m_target = -1;
    m_prev   = 0;
    m_lit    = 0;
    m_btn    = '0;
  endtask

  task automatic model_step(input logic f, input logic [12:0] r, input logic [N-1:0] b);
    logic [N-1:0] press = b & ~m_btn;
    int   idx = pick(int'(r), N, m_prev);
    logic hit = 1'b0, miss = 1'b0, load = 1'b0;
    exp_t e;
    if (m_target < 0) begin
      if (f) load = 1'b1;
    end else if (press[m_target]) begin
      hit = 1'b1;
      if (f) load = 1'b1;
      else m_target = -1;
    end else if (press != 0) begin
      miss = 1'b1;
      if (m_lit == ON) m_target = -1;
      else m_lit++;
    end else if (f) begin
      miss = 1'b1;
      load = 1'b1;
    end else if (m_lit == ON) begin
      miss = 1'b1;
      m_target = -1;
    end else begin
      m_lit++;
    end
    if (load) begin
      m_target = idx;
      m_prev   = idx;
      m_lit    = 1;
    end
    m_btn    = b;
    e.led    = (m_target < 0) ? '0 : N'(1) << m_target;
    e.active = (m_target >= 0);
    e.hit    = hit;
    e.miss   = miss;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic f, input logic [12:0] r, input logic [N-1:0] b);
    @(negedge clk);
    freq = f;
    rnd  = r;
    btn  = b;
    model_step(f, r, b);
  endtask

  // Settle just past the edge that consumes the last stepped inputs.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("led_onehot", 32'(led_onehot), 32'(e.led));
        check("active", 32'(active), 32'(e.active));
        check("hit_pulse", 32'(hit_pulse), 32'(e.hit));
        check("miss_pulse", 32'(miss_pulse), 32'(e.miss));
      end
    end
  end

  initial begin : driver
    logic [N-1:0] b;
    rst_n = 1'b0;
    freq  = 1'b0; rnd  = '0; btn  = '0;
    freq6 = 1'b0; rnd6 = '0; btn6 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_led", 32'(led_onehot), 32'h0);
    check("reset_active", 32'(active), 32'h0);
    check("reset_pulses", 32'({hit_pulse, miss_pulse}), 32'h0);
    rst_n = 1'b1;

    // Six-LED instance: modulo fold and no-repeat bump.
    @(negedge clk); freq6 = 1'b1; rnd6 = 13'h0007;
    @(negedge clk); freq6 = 1'b0;
    check("fold6_led", 32'(led6), 32'h02);
    @(negedge clk); freq6 = 1'b1; rnd6 = 13'h0001;
    @(negedge clk); freq6 = 1'b0;
    check("norepeat6_led", 32'(led6), 32'h04);
    check("norepeat6_miss", 32'(miss6), 32'h1);
    @(negedge clk); freq6 = 1'b1; rnd6 = 13'h0006;
    @(negedge clk); freq6 = 1'b0;
    check("fold6_zero_led", 32'(led6), 32'h01);

    // First target after reset.
    step(1'b1, 13'h0005, '0);
    settle();
    check("first_led", 32'(led_onehot), 32'h20);
    check("first_active", 32'(active), 32'h1);

    // Retarget to 3, then a correct press, then a held button.
    step(1'b1, 13'h0003, '0);
    step(1'b0, '0, 8'h08);
    settle();
    check("hit_pulse", 32'(hit_pulse), 32'h1);
    check("hit_led", 32'(led_onehot), 32'h0);
    repeat (3) step(1'b0, '0, 8'h08);
    settle();
    check("held_no_hit", 32'(hit_pulse), 32'h0);
    step(1'b0, '0, '0);

    // Wrong press, then timeout exactly ON cycles after lighting.
    step(1'b1, 13'h0001, '0);
    step(1'b1, 13'h0003, '0);
    for (int i = 1; i <= ON - 1; i++) step(1'b0, '0, (i == 1) ? 8'h01 : 8'h00);
    settle();
    check("timeout_still_lit", 32'(led_onehot), 32'h08);
    step(1'b0, '0, '0);
    settle();
    check("timeout_led", 32'(led_onehot), 32'h0);
    check("timeout_miss", 32'(miss_pulse), 32'h1);

    // freq mid-window abandons the target and restarts the window.
    step(1'b1, 13'h0001, '0);
    repeat (3) step(1'b0, '0, '0);
    step(1'b1, 13'h0006, '0);
    settle();
    check("abandon_miss", 32'(miss_pulse), 32'h1);
    check("abandon_led", 32'(led_onehot), 32'h40);
    repeat (ON - 1) step(1'b0, '0, '0);
    settle();
    check("abandon_window_lit", 32'(led_onehot), 32'h40);
    step(1'b0, '0, '0);
    settle();
    check("abandon_window_end", 32'(led_onehot), 32'h0);

    // Randomised play; presses on the lit target are biased in to exercise hits.
    b = '0;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 5))
        0: b = N'($urandom);
        1: b = (m_target >= 0) ? (N'(1) << m_target) : N'(1) << $urandom_range(0, N-1);
        2: b = '0;
        default: ;
      endcase
      step(($urandom_range(0, 5) == 0), 13'($urandom), b);
    end
    step(1'b0, '0, '0);

    // Asynchronous reset between edges while a target is lit.
    step(1'b1, 13'h0002, '0);
    step(1'b0, '0, '0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_led", 32'(led_onehot), 32'h0);
    check("async_active", 32'(active), 32'h0);
    check("async_pulses", 32'({hit_pulse, miss_pulse}), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 13'h0000, '0);
    step(1'b0, '0, '0);

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
